// File: rtl/aes_enc_if.sv
// Handshake and data bundle between a plaintext/key source, the iterative AES core
// and the ciphertext consumer.
interface aes_enc_if #(
   parameter int unsigned ROUNDS = 10
) ();
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] round_keys [0:ROUNDS];
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;

   modport master (
      output in_valid, plaintext, round_keys, out_ready,
      input  in_ready, out_valid, ciphertext, busy
   );

   modport slave (
      input  in_valid, plaintext, round_keys, out_ready,
      output in_ready, out_valid, ciphertext, busy
   );
endinterface

// File: rtl/aes_encrypt_iterative.sv
// Iterative AES encryption: one full round per clock using an externally expanded key schedule.
// Defining AES_ENC_ROUND_DEBUG_EN adds the dbg_round / dbg_state observation ports.
module aes_encrypt_iterative #(
   parameter int unsigned ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   aes_enc_if.slave     bus
`ifdef AES_ENC_ROUND_DEBUG_EN
   ,
   output logic [3:0]   dbg_round,
   output logic [127:0] dbg_state
`endif
);
   localparam int unsigned CNT_W = 4;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [1:0]       fsm_q, fsm_d;
   logic [127:0]     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;

   logic [7:0]       sb [16];
   logic [7:0]       sr [16];
   logic [7:0]       mc [16];
   logic [127:0]     mix_sel;
   logic [127:0]     round_out;
   logic             last_round;

   assign last_round = (cnt_q == LAST_CNT);

   // SubBytes: one table lookup per state byte (byte i lives at [127-8i -: 8])
   for (genvar i = 0; i < 16; i++) begin : g_sbox
      assign sb[i] = SBOX[state_q[127-8*i -: 8]];
   end

   // ShiftRows (row r rotated left by r), MixColumns, and final-round bypass
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[r+4*c] = sb[r + 4*((c+r)%4)];
      end

      assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);

      for (genvar r = 0; r < 4; r++) begin : g_sel
         assign mix_sel[127-8*(r+4*c) -: 8] = last_round ? sr[r+4*c] : mc[r+4*c];
      end
   end

   assign round_out = mix_sel ^ bus.round_keys[cnt_q];

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   // Next state; in_ready/busy are registered copies of the next FSM state decode
   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      case (fsm_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               state_d = bus.plaintext ^ bus.round_keys[0];
               cnt_d   = CNT_W'(1);
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = round_out;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_round) begin
               fsm_d       = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = '0;
               fsm_d       = IDLE;
            end
         end
         default: begin
            fsm_d       = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
         end
      endcase
      in_ready_d = (fsm_d == IDLE);
      busy_d     = (fsm_d != IDLE);
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.ciphertext = state_q;
   assign bus.busy       = busy_q;

`ifdef AES_ENC_ROUND_DEBUG_EN
   assign dbg_round = cnt_q;
   assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Bench for aes_encrypt_iterative: FIPS-197 vectors, handshake corner cases and random
// blocks checked against an algebraic AES-128 reference model.
module tb_aes_encrypt_iterative;
   localparam int unsigned ROUNDS = 10;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic clk;
   logic rst;
   aes_enc_if #(.ROUNDS(ROUNDS)) bus ();
`ifdef AES_ENC_ROUND_DEBUG_EN
   logic [3:0]   dbg_round;
   logic [127:0] dbg_state;
`endif

   aes_encrypt_iterative #(.ROUNDS(ROUNDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef AES_ENC_ROUND_DEBUG_EN
      ,
      .dbg_round (dbg_round),
      .dbg_state (dbg_state)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [7:0]   sb_m [256];
   logic [127:0] rk_m [0:ROUNDS];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
      return 8'((v << k) | (v >> (8 - k)));
   endfunction

   // AES-128 key schedule; result also drives the DUT key array
   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= int'(ROUNDS); r++) begin
         rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         bus.round_keys[r] = rk_m[r];
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      logic [127:0] res;
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_m[0][127-8*i -: 8];
      for (int rnd = 1; rnd <= int'(ROUNDS); rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb_m[s[i]];
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               s[row+4*col] = t[row + 4*((col+row)%4)];
         if (rnd != int'(ROUNDS)) begin
            for (int col = 0; col < 4; col++)
               for (int row = 0; row < 4; row++) begin
                  acc = 8'h00;
                  for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-row+4)%4], s[j+4*col]);
                  t[row+4*col] = acc;
               end
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_m[rnd][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] pt);
      int k;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      check("send_ready", 128'(bus.in_ready), 128'd1);
      bus.plaintext = pt;
      bus.in_valid  = 1'b1;
      step();
      bus.in_valid  = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      check({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
   endtask

   initial begin
      logic [7:0]   inv;
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] exp_ct;
      int           n;
      int           acc_n;
      int           acc_cyc [2];
      logic         will;

      // S-box from multiplicative inverse (x^254) and affine map
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
         sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.plaintext = '0;
      expand_key('0);
      repeat (3) step();
      check("rst_in_ready", 128'(bus.in_ready), 128'd1);
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_ct", bus.ciphertext, 128'd0);
      rst = 1'b0;
      step();

      // App. B with exact latency
      expand_key(KEY_B);
      bus.out_ready = 1'b1;
      send(PT_B);
      check("b_busy", 128'(bus.busy), 128'd1);
      check("b_in_ready_low", 128'(bus.in_ready), 128'd0);
      wait_valid("b", n);
      check("b_latency", 128'(n), 128'd10);
      check("b_ct", bus.ciphertext, CT_B);
      check("b_ct_model", bus.ciphertext, aes_ref(PT_B));
      step();
      check("b_hs_valid", 128'(bus.out_valid), 128'd0);
      check("b_hs_ready", 128'(bus.in_ready), 128'd1);

      // App. C.1 with output backpressure
      expand_key(KEY_C);
      bus.out_ready = 1'b0;
      send(PT_C);
      wait_valid("c", n);
      check("c_latency", 128'(n), 128'd10);
      check("c_ct", bus.ciphertext, CT_C);
      for (int k = 0; k < 5; k++) begin
         step();
         check("c_hold_valid", 128'(bus.out_valid), 128'd1);
         check("c_hold_ct", bus.ciphertext, CT_C);
      end
      bus.out_ready = 1'b1;
      step();
      check("c_release_valid", 128'(bus.out_valid), 128'd0);
      check("c_release_ready", 128'(bus.in_ready), 128'd1);
      check("c_release_busy", 128'(bus.busy), 128'd0);

      // in_valid pulses during ROUND are ignored
      expand_key(KEY_B);
      send(PT_B);
      for (int k = 0; k < 4; k++) begin
         bus.in_valid  = 1'b1;
         bus.plaintext = '1;
         step();
         check("ign_ready_low", 128'(bus.in_ready), 128'd0);
      end
      bus.in_valid  = 1'b0;
      bus.plaintext = PT_B;
      wait_valid("ign", n);
      check("ign_ct", bus.ciphertext, CT_B);
      step();
      check("ign_idle", 128'(bus.busy), 128'd0);

      // All-zero vector, back-to-back with in_valid held high
      expand_key('0);
      bus.plaintext = '0;
      bus.in_valid  = 1'b1;
      acc_n = 0;
      acc_cyc[0] = 0;
      acc_cyc[1] = 0;
      for (int k = 0; k < 30; k++) begin
         will = bus.in_valid && bus.in_ready;
         step();
         if (will) begin
            if (acc_n < 2) acc_cyc[acc_n] = cyc;
            acc_n++;
         end
         if (bus.out_valid === 1'b1) check("zero_ct", bus.ciphertext, CT_Z);
      end
      bus.in_valid = 1'b0;
      check("b2b_period", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
      wait_valid("zero_drain", n);
      check("zero_drain_ct", bus.ciphertext, CT_Z);
      step();

      // Asynchronous reset in the middle of a block
      expand_key(KEY_B);
      send(PT_B);
      repeat (4) step();
      check("mid_busy_before", 128'(bus.busy), 128'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 128'(bus.out_valid), 128'd0);
      check("mid_rst_busy", 128'(bus.busy), 128'd0);
      check("mid_rst_ct", bus.ciphertext, 128'd0);
      check("mid_rst_ready", 128'(bus.in_ready), 128'd1);
      step();
      rst = 1'b0;
      step();
      send(PT_B);
      wait_valid("post_rst", n);
      check("post_rst_latency", 128'(n), 128'd10);
      check("post_rst_ct", bus.ciphertext, CT_B);
      step();

      // Random keys and plaintexts with random backpressure
      for (int t = 0; t < 20; t++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand_key(key);
         exp_ct = aes_ref(pt);
         bus.out_ready = ($urandom_range(1, 0) == 0);
         send(pt);
         wait_valid("rnd", n);
         check("rnd_latency", 128'(n), 128'd10);
         check("rnd_ct", bus.ciphertext, exp_ct);
         if (!bus.out_ready) begin
            repeat ($urandom_range(3, 0)) step();
            check("rnd_hold_ct", bus.ciphertext, exp_ct);
            bus.out_ready = 1'b1;
         end
         step();
         check("rnd_hs_valid", 128'(bus.out_valid), 128'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_encrypt_iterative.md
Name: aes_encrypt_iterative

Overview:
- Iterative AES encryption core: one AES round per clock, driven by the round-key array produced by aes_key_expansion.
- Sits directly downstream of key expansion and consumes its expanded_keys array unchanged.
- Valid/ready handshake on both input and output.
- One block in flight at a time; ROUNDS+1 cycles from acceptance to ciphertext valid.

Parameters:
- ROUNDS, 10: number of AES rounds (10/12/14 for AES-128/192/256); sizes the round_keys array and the round counter end value.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext offered
- in_ready  output  1  core idle; can accept a block
- plaintext  input  128  state bytes, FIPS-197 column-major; byte 0 = [127:120]
- round_keys  input  128 x [0:ROUNDS]  round key r in element r; word w[4r] in [127:96]
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  result, same byte order as plaintext
- busy  output  1  high in ROUND or DONE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst).
- Reset values: FSM=IDLE, state register=0, round counter=0, out_valid=0, ciphertext=0, busy=0. in_ready=1, decoded from IDLE.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge (in_valid & in_ready): state <= plaintext ^ round_keys[0]; cnt <= 1; go to ROUND.
- ROUND:
  - in_ready=0; in_valid is ignored.
  - Each edge: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), round_keys[cnt]); cnt <= cnt+1.
  - When cnt==ROUNDS: MixColumns is omitted, state <= final result, go to DONE.
- DONE:
  - out_valid=1; ciphertext=state register (registered output).
  - out_valid and ciphertext stay stable while out_ready=0.
  - Output handshake edge (out_valid & out_ready): out_valid <= 0; go to IDLE. A new block cannot be accepted on that same edge.
- Latency:
  - Counting the accept edge as edge 0, out_valid rises after edge ROUNDS.
  - Minimum block-to-block period is ROUNDS+2 cycles (out_ready held high).
- Round-key sampling:
  - round_keys is read combinationally each round.
  - The source must hold round_keys stable from the accept edge through edge ROUNDS.
  - A key change mid-block corrupts that block only; no error flag.
- Round datapath:
  - SubBytes: 16 instances of the team's standard AES S-box table.
  - ShiftRows: row r rotated left by r bytes.
  - MixColumns: GF(2^8) multiply with xtime; reduction polynomial 0x11b.
  - Pure combinational logic between state-register stages.
- cnt is 4 bits and is never compared beyond ROUNDS; no wrap-around is possible.
- Reset mid-operation, from any state, immediately returns all outputs to their reset values and discards the in-flight block.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: AES_ENC_ROUND_DEBUG_EN.
- When defined, two extra outputs are added:
  - dbg_round (4 bits): current cnt; 0 in IDLE, held at ROUNDS+1 in DONE.
  - dbg_state (128 bits): live state register, updated every round.
- When undefined, the ports and their logic are absent; the functional interface is otherwise identical.

Test Plan:
- FIPS-197 App. B: round_keys from aes_key_expansion with key 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32; out_valid rises exactly after edge 10.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f; plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Zero vector and back-to-back:
  - All-zero key and plaintext -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - With out_ready=1, the next accept happens 12 cycles after the previous accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and ciphertext unchanged; release -> one handshake, then in_ready=1 on the next cycle.
- Busy ignore: pulse in_valid with plaintext ffff…ff during ROUND -> ignored; first block's ciphertext still correct; in_ready=0 throughout.
- Reset mid-operation: assert rst asynchronously at round 5 -> out_valid, ciphertext, busy go to 0 without waiting for a clock edge; after release, a fresh App. B block completes correctly.
